dsc_mul_n: RTL and testbench
============================

# dsc_mul_n

Parametrised deterministic stochastic-computing (DSC) multiplier. It multiplies `NUM_INPUTS` unsigned `SNG_WIDTH`-bit operands exactly, using unary stochastic streams built by clock division. All operand counters run on the single `clk` with cascaded enables; there are no ripple clocks. On start, the block captures and sorts the operands, streams their AND into an output counter, and optionally stops early once the slowest stream goes to zero. It is the general N-input successor of the fixed 3-input, 8-bit serial DSC multiplier and sits wherever the design needs a start/done product engine.

## Interface

Parameters:
- `SNG_WIDTH`, default 8: operand width W.
- `NUM_INPUTS`, default 3: operand count N, at least 2.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset, synchronous and active-high.
- `start`, input, 1: request a new product.
- `x`, input, N*W: packed operands; operand i is `x[i*W +: W]`.
- `busy`, output, 1: high during SORT and RUN.
- `done`, output, 1: high while in DONE.
- `z`, output, N*W: product count.

## Operation

States are IDLE, SORT, RUN and DONE.

- **IDLE / DONE:** `start`=1 captures `x` into registers `v[0..N-1]` and clears `z` and all stream counters. The next state is SORT.
- **`start` at other times:** ignored in SORT and RUN.
- **SORT:** runs for exactly N cycles. Each cycle performs one odd-even transposition pass, alternating even and odd pairs and starting with even pairs. The result is `v` sorted descending: `v[0]` is the maximum and `v[N-1]` is the minimum. The next state is RUN, or DONE directly when the RUN length below is zero.
- **RUN:** each cycle does the following.
  - Stream counter `c[i]` (W bits, 0..2^W-1) increments when every `c[j]` with j<i equals 2^W-1. `c[0]` increments every cycle.
  - Stream bit: `s[i] = (c[i] < v[i])`.
  - If the AND of all `s[i]` is 1, `z` increments by 1.
- **RUN end:** RUN ends after the last cycle of the required count and the state moves to DONE.
- **Result:** `z` equals the product of all operands exactly. `z` is never saturated; the maximum (2^W-1)^N fits in N*W bits.
- **Ordering rationale:** the fastest counter gets the largest operand and the slowest gets the smallest, which maximises early-stop savings.
- **DONE:** `z` holds its value until the next accepted `start` clears it.

## Timing

- **Reset:** `rst`=1 at a clock edge forces the following, regardless of state:
  - state = IDLE;
  - `busy`=0, `done`=0, `z`=0;
  - all `c` and `v` registers = 0.
- **Reset mid-operation:** the run is aborted, with no partial `done`.
- **Start:** `start` sampled at edge t gives SORT in cycles t+1..t+N, with `busy`=1 from t+1.
- **RUN length:** RUN occupies cycles t+N+1..t+N+L, where L is the RUN length (see Configuration).
- **Completion:** `done`=1 and `busy`=0 from cycle t+N+L+1. For L=0 this is cycle t+N+1.
- **`z` latency:** `z` is updated one cycle after the qualifying AND bit.
- **Start while DONE:** `done` drops in the next cycle.

## Configuration

- **Macro:** `DSC_EARLY_STOP_EN`.
- **Defined:** L = `v[N-1]` * 2^((N-1)*W). Streams are thermometer-coded, so once `c[N-1]` reaches `v[N-1]` no further 1s are possible. A zero minimum operand gives L=0.
- **Undefined:** L = 2^(N*W) always, the full period. Every counter ends wrapped to 0.
- **Either setting:** `z` is identical.

## Structure

- **Package `dsc_pkg`:**
  - the state enum (IDLE, SORT, RUN, DONE);
  - a function for the N*W output width;
  - a constant for the counter all-ones value.
- **Sub-module `dsc_unary_sng`:**
  - contents: a W-bit counter with enable, a comparison against its operand, and a wrap flag (counter at all-ones AND enable);
  - cascading: `dsc_mul_n` instantiates N of these and chains the wrap flags as enables.
- **In `dsc_mul_n`:** the sort network, FSM, RUN length counter or early-stop compare, and output counter.

## Test plan

All scenarios use W=4, N=3.

- **Nominal:** `x`=(3,15,8) -> `z`=360.
  - With `DSC_EARLY_STOP_EN`: RUN lasts 768 cycles, and `done` is seen 772 cycles after the `start` edge.
  - Without the macro: RUN lasts 4096 cycles.
- **Zero operand:** `x`=(5,0,9) -> `z`=0.
  - With `DSC_EARLY_STOP_EN`: `done` is seen at t+4 and no RUN cycles occur.
  - Without the macro: `done` is seen at t+4100.
- **All-max:** `x`=(15,15,15) -> `z`=3375; early-stop RUN is 3840 cycles.
- **Sort check:** any permutation of (2,7,11) -> `z`=154, and after SORT `v` = (11,7,2) for every permutation.
- **Start during busy:** pulse `start` with different `x` during RUN -> ignored, result unchanged. A second `start` in DONE -> `done` drops next cycle, `z` clears, and the new result is correct.
- **Reset mid-run:** assert `rst` 100 cycles into RUN -> the next cycle shows IDLE, `z`=0, `busy`=0, `done`=0. A subsequent `start` produces a correct result.

Source files
------------

// File: rtl/dsc_pkg.sv
// dsc_pkg: shared state encoding and sizing helpers for the DSC multiplier.
package dsc_pkg;

    typedef enum logic [1:0] {IDLE, SORT, RUN, DONE} dsc_state_e;

    localparam int DSC_MAX_W = 32;
    localparam logic [DSC_MAX_W-1:0] DSC_ONES = '1;

    function automatic int dsc_out_width(input int n, input int w);
        return n * w;
    endfunction

endpackage

// File: rtl/dsc_unary_sng.sv
// dsc_unary_sng: W-bit clock-division stream generator; wrap_o enables the next stage.
// With DSC_EARLY_STOP_EN the count is exported for the early-stop compare.
module dsc_unary_sng
    import dsc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] v_i,
`ifdef DSC_EARLY_STOP_EN
    output logic [W-1:0] c_o,
`endif
    output logic         s_o,
    output logic         wrap_o
);
    localparam logic [W-1:0] ONES = DSC_ONES[W-1:0];

    logic [W-1:0] c_q;
    logic [W-1:0] c_d;

    assign c_d = en_i ? c_q + 1'b1 : c_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) c_q <= '0;
        else c_q <= c_d;
    end

    assign s_o = c_q < v_i;
    assign wrap_o = en_i && c_q == ONES;
`ifdef DSC_EARLY_STOP_EN
    assign c_o = c_q;
`endif

endmodule

// File: rtl/dsc_mul_n.sv
// dsc_mul_n: N-input exact deterministic stochastic multiplier (sort, stream, count).
// Build option DSC_EARLY_STOP_EN ends RUN once the slowest stream can no longer be 1.
module dsc_mul_n
    import dsc_pkg::*;
#(
    parameter int SNG_WIDTH  = 8,
    parameter int NUM_INPUTS = 3
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    input  logic [NUM_INPUTS*SNG_WIDTH-1:0]                   x,
    output logic                                              busy,
    output logic                                              done,
    output logic [dsc_out_width(NUM_INPUTS, SNG_WIDTH)-1:0]   z
);
    localparam int W  = SNG_WIDTH;
    localparam int N  = NUM_INPUTS;
    localparam int ZW = dsc_out_width(N, W);
    localparam int PW = $clog2(N + 1);

    dsc_state_e    state_q;
    dsc_state_e    state_d;
    logic [W-1:0]  v_q [N];
    logic [W-1:0]  v_d [N];
    logic [PW-1:0] pass_q;
    logic [ZW-1:0] z_q;
    logic          busy_q;
    logic          done_q;
    logic          clr;
    logic          last;
    logic [N:0]    en;
    logic [N-1:0]  s;
`ifdef DSC_EARLY_STOP_EN
    localparam logic [W-1:0] ONES = DSC_ONES[W-1:0];
    logic [W-1:0]  c [N];
    logic          lo_max;
`endif

    assign clr   = start && (state_q == IDLE || state_q == DONE);
    assign en[0] = state_q == RUN;

    for (genvar i = 0; i < N; i++) begin : g_sng
        dsc_unary_sng #(.W(W)) u_sng (
            .clk    (clk),
            .rst    (rst),
            .clr_i  (clr),
            .en_i   (en[i]),
            .v_i    (v_q[i]),
`ifdef DSC_EARLY_STOP_EN
            .c_o    (c[i]),
`endif
            .s_o    (s[i]),
            .wrap_o (en[i+1])
        );
    end

    // One odd-even transposition pass; even pairs on even pass numbers.
    always_comb begin
        for (int i = 0; i < N; i++) v_d[i] = v_q[i];
        for (int i = 0; i + 1 < N; i++) begin
            if (((i % 2) == 1) == pass_q[0] && v_q[i] < v_q[i+1]) begin
                v_d[i]   = v_q[i+1];
                v_d[i+1] = v_q[i];
            end
        end
    end

    // Full period ends on the last stage wrap; early stop when the slowest counter reaches its operand.
    always_comb begin
        last = en[N];
`ifdef DSC_EARLY_STOP_EN
        lo_max = state_q == RUN;
        for (int i = 0; i < N - 1; i++) lo_max = lo_max && c[i] == ONES;
        last = last || (lo_max && c[N-1] + 1'b1 == v_q[N-1]);
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = start ? SORT : state_q;
`ifdef DSC_EARLY_STOP_EN
            SORT: state_d = pass_q == PW'(N - 1) ? (v_d[N-1] == '0 ? DONE : RUN) : SORT;
`else
            SORT: state_d = pass_q == PW'(N - 1) ? RUN : SORT;
`endif
            RUN: state_d = last ? DONE : RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= '0;
            pass_q  <= '0;
            for (int i = 0; i < N; i++) v_q[i] <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= state_d == SORT || state_d == RUN;
            done_q  <= state_d == DONE;
            if (clr) begin
                z_q    <= '0;
                pass_q <= '0;
                for (int i = 0; i < N; i++) v_q[i] <= x[i*W +: W];
            end else if (state_q == SORT) begin
                pass_q <= pass_q + 1'b1;
                for (int i = 0; i < N; i++) v_q[i] <= v_d[i];
            end else if (state_q == RUN && &s) begin
                z_q <= z_q + 1'b1;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign z    = z_q;

endmodule

// File: tb/tb_dsc_mul_n.sv
// tb_dsc_mul_n: directed and random products checked against an arithmetic reference model.
module tb_dsc_mul_n;
    import dsc_pkg::*;

    localparam int W = 4;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [N*W-1:0] x = '0;
    logic busy;
    logic done;
    logic [N*W-1:0] z;
    int total = 0;
    int bad = 0;

    dsc_mul_n #(.SNG_WIDTH(W), .NUM_INPUTS(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .busy  (busy),
        .done  (done),
        .z     (z)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_prod(input int ops[N]);
        longint p = 1;
        for (int i = 0; i < N; i++) p = p * ops[i];
        return p;
    endfunction

    function automatic longint ref_len(input int ops[N]);
        int mn = ops[0];
        for (int i = 1; i < N; i++) if (ops[i] < mn) mn = ops[i];
`ifdef DSC_EARLY_STOP_EN
        return longint'(mn) << ((N - 1) * W);
`else
        return longint'(1) << (N * W);
`endif
    endfunction

    // Drives one start pulse; returns at the first sample after the start edge.
    task automatic launch(input int ops[N], input string tag);
        @(negedge clk);
        for (int i = 0; i < N; i++) x[i*W +: W] = W'(ops[i]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy@t+1"}, busy, 1);
        check({tag, " done@t+1"}, done, 0);
        check({tag, " z cleared"}, z, 0);
    endtask

    task automatic finish_op(input int ops[N], input string tag, input int k0);
        int k = k0;
        int lim = N + int'(ref_len(ops)) + 1;
        int srt[N];
        int tmp;
        while (done !== 1'b1 && k < lim + 16) begin
            @(negedge clk);
            k++;
        end
        check({tag, " done latency"}, k, lim);
        check({tag, " z"}, z, ref_prod(ops));
        check({tag, " busy@done"}, busy, 0);
        srt = ops;
        for (int a = 0; a < N; a++)
            for (int b = 0; b + 1 < N; b++)
                if (srt[b] < srt[b+1]) begin
                    tmp = srt[b];
                    srt[b] = srt[b+1];
                    srt[b+1] = tmp;
                end
        for (int i = 0; i < N; i++) check($sformatf("%s sorted v[%0d]", tag, i), dut.v_q[i], srt[i]);
    endtask

    initial begin
        int ops[N];
        int alt[N];
        int k;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset z", z, 0);
        check("reset state", dut.state_q, IDLE);
        rst = 1'b0;

        ops = '{3, 15, 8};
        launch(ops, "nominal");
        finish_op(ops, "nominal", 1);

        ops = '{5, 0, 9};
        launch(ops, "zero");
        finish_op(ops, "zero", 1);

        ops = '{15, 15, 15};
        launch(ops, "allmax");
        finish_op(ops, "allmax", 1);

        ops = '{2, 7, 11};
        launch(ops, "perm0");
        finish_op(ops, "perm0", 1);
        ops = '{11, 2, 7};
        launch(ops, "perm1");
        finish_op(ops, "perm1", 1);
        ops = '{7, 11, 2};
        launch(ops, "perm2");
        finish_op(ops, "perm2", 1);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) ops[i] = int'($urandom_range(0, 15));
            launch(ops, $sformatf("rand%0d", r));
            finish_op(ops, $sformatf("rand%0d", r), 1);
        end

        // A start pulse in RUN must be ignored.
        ops = '{6, 9, 4};
        alt = '{1, 1, 1};
        launch(ops, "ignore");
        repeat (N + 50) @(negedge clk);
        k = 1 + N + 50;
        for (int i = 0; i < N; i++) x[i*W +: W] = W'(alt[i]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k++;
        check("ignore busy", busy, 1);
        finish_op(ops, "ignore", k);

        ops = '{13, 1, 10};
        launch(ops, "restart");
        finish_op(ops, "restart", 1);

        ops = '{9, 12, 14};
        launch(ops, "abort");
        repeat (N + 99) @(negedge clk);
        check("abort busy before rst", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort state", dut.state_q, IDLE);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort z", z, 0);
        for (int i = 0; i < N; i++) check($sformatf("abort v[%0d]", i), dut.v_q[i], 0);
        repeat (4) @(negedge clk);
        check("abort idle done", done, 0);
        launch(ops, "after abort");
        finish_op(ops, "after abort", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
